// File: rtl/tile_lane_engine.sv
// Falling-tile game core: row buffer, scroll offset, key judging, speed ramp,
// score, game state and a registered per-pixel tile/hit/border lookup.
module tile_lane_engine #(
    parameter int unsigned LANES          = 5,
    parameter int unsigned ROWS           = 4,
    parameter int unsigned ROW_H          = 120,
    parameter int unsigned LANE_W         = 128,
    parameter int unsigned SPEED_INIT     = 1,
    parameter int unsigned SPEED_STEP     = 2,
    parameter int unsigned SPEED_MAX      = 12,
    parameter int unsigned ROWS_PER_LEVEL = 5,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5,
    localparam int unsigned LW            = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic          pixel_clk,
    input  logic          Reset_n,
    input  logic          frame_tick,
    input  logic          key_valid,
    input  logic [LW-1:0] key_lane,
    input  logic          restart,
    input  logic [9:0]    draw_x,
    input  logic [9:0]    draw_y,
    output logic          px_tile,
    output logic          px_hit,
    output logic          px_border,
    output logic [1:0]    state,
    output logic [3:0]    speed,
    output logic [15:0]   score,
    output logic          miss
);
    localparam int unsigned OW  = $clog2(ROW_H + SPEED_MAX + 1);
    localparam int unsigned LVW = $clog2(ROWS_PER_LEVEL + 1);

    typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StOver = 2'd2} state_e;

    state_e        r_state, w_state;
    logic [LW-1:0] r_rows [ROWS];
    logic [LW-1:0] w_rows [ROWS];
    logic [LW-1:0] r_inc, w_inc;
    logic          r_bh, w_bh;
    logic [OW-1:0] r_off, w_off, w_sum;
    logic [3:0]    r_speed, w_speed;
    logic [4:0]    w_spd_sum;
    logic [LVW-1:0] r_lvl, w_lvl;
    logic [15:0]   r_score, w_score;
    logic          r_miss, w_miss;
    logic [7:0]    r_lfsr;
    logic          w_hit_eff, w_bad_key, w_px_clear;
    logic          r_px_tile, r_px_hit, r_px_border;
    logic          w_tile, w_hit, w_border, w_on_row;
    logic [9:0]    w_lane, w_xm;
    logic [11:0]   w_y;
    logic [10:0]   w_row;
    logic [LW-1:0] w_sel;

    // Initial column pattern is a descending staircase, bottom row on lane 1 by default.
    function automatic logic [LW-1:0] init_lane(int k);
        int v;
        v = (int'(LANES) - 1 - k) % int'(LANES);
        if (v < 0) v += int'(LANES);
        return LW'(v);
    endfunction

    always_comb begin
        w_state    = r_state;
        w_rows     = r_rows;
        w_inc      = r_inc;
        w_bh       = r_bh;
        w_off      = r_off;
        w_speed    = r_speed;
        w_lvl      = r_lvl;
        w_score    = r_score;
        w_miss     = 1'b0;
        w_px_clear = 1'b0;
        w_hit_eff  = r_bh;
        w_bad_key  = 1'b0;
        w_sum      = r_off + OW'(r_speed);
        w_spd_sum  = {1'b0, r_speed} + 5'(SPEED_STEP);
        unique case (r_state)
            StIdle, StRun: begin
                if (key_valid) begin
                    if (key_lane == r_rows[ROWS-1]) begin
                        w_state = StRun;
                        if (!r_bh) begin
                            w_bh      = 1'b1;
                            w_hit_eff = 1'b1;
                            if (r_score != 16'hFFFF) w_score = r_score + 16'd1;
                        end
                    end else begin
                        w_bad_key = 1'b1;
                        w_miss    = 1'b1;
                        w_state   = StOver;
                    end
                end
                // A hit landing on the shifting tick still rescues the bottom row.
                if (r_state == StRun && frame_tick && !w_bad_key) begin
                    if (w_sum < OW'(ROW_H)) begin
                        w_off = w_sum;
                    end else if (!w_hit_eff) begin
                        w_miss  = 1'b1;
                        w_state = StOver;
                    end else begin
                        for (int k = int'(ROWS) - 1; k > 0; k--) w_rows[k] = r_rows[k-1];
                        w_rows[0] = r_inc;
                        w_inc     = LW'(r_lfsr % 8'(LANES));
                        w_bh      = 1'b0;
                        w_off     = w_sum - OW'(ROW_H);
                        if (r_lvl == LVW'(ROWS_PER_LEVEL - 1)) begin
                            w_lvl = '0;
                            if (r_speed == 4'd1)                  w_speed = 4'd2;
                            else if (w_spd_sum >= 5'(SPEED_MAX))  w_speed = 4'(SPEED_MAX);
                            else                                  w_speed = w_spd_sum[3:0];
                        end else begin
                            w_lvl = r_lvl + LVW'(1);
                        end
                    end
                end
            end
            StOver: begin
                if (restart) begin
                    for (int k = 0; k < int'(ROWS); k++) w_rows[k] = init_lane(k);
                    w_inc      = '0;
                    w_bh       = 1'b0;
                    w_off      = '0;
                    w_speed    = 4'(SPEED_INIT);
                    w_lvl      = '0;
                    w_score    = '0;
                    w_state    = StIdle;
                    w_px_clear = 1'b1;
                end
            end
            default: w_state = StIdle;
        endcase
    end

    // Pixel lookup; a negative scrolled y falls in the incoming row above the screen.
    always_comb begin
        w_lane   = draw_x / 10'(LANE_W);
        w_xm     = draw_x % 10'(LANE_W);
        w_y      = 12'(draw_y) - 12'(r_off);
        w_row    = w_y[10:0] / 11'(ROW_H);
        w_sel    = r_inc;
        w_on_row = 1'b0;
        if (w_y[11]) begin
            w_on_row = 1'b1;
        end else begin
            for (int k = 0; k < int'(ROWS); k++) begin
                if (w_row == 11'(k)) begin
                    w_sel    = r_rows[k];
                    w_on_row = 1'b1;
                end
            end
        end
        w_tile   = w_on_row && (w_lane < 10'(LANES)) && (10'(w_sel) == w_lane);
        w_hit    = w_tile && !w_y[11] && (w_row == 11'(ROWS - 1)) && r_bh;
        w_border = (w_xm == 10'd0) || (w_xm == 10'(LANE_W - 1));
    end

    always_ff @(posedge pixel_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= StIdle;
            for (int k = 0; k < int'(ROWS); k++) r_rows[k] <= init_lane(k);
            r_inc       <= '0;
            r_bh        <= 1'b0;
            r_off       <= '0;
            r_speed     <= 4'(SPEED_INIT);
            r_lvl       <= '0;
            r_score     <= '0;
            r_miss      <= 1'b0;
            r_lfsr      <= LFSR_SEED;
            r_px_tile   <= 1'b0;
            r_px_hit    <= 1'b0;
            r_px_border <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_rows      <= w_rows;
            r_inc       <= w_inc;
            r_bh        <= w_bh;
            r_off       <= w_off;
            r_speed     <= w_speed;
            r_lvl       <= w_lvl;
            r_score     <= w_score;
            r_miss      <= w_miss;
            r_lfsr      <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
            r_px_tile   <= w_tile && !w_px_clear;
            r_px_hit    <= w_hit && !w_px_clear;
            r_px_border <= w_border && !w_px_clear;
        end
    end

    assign state     = r_state;
    assign speed     = r_speed;
    assign score     = r_score;
    assign miss      = r_miss;
    assign px_tile   = r_px_tile;
    assign px_hit    = r_px_hit;
    assign px_border = r_px_border;

endmodule

// File: doc/tile_lane_engine.md
Name: tile_lane_engine

Overview:
- Parametrised next-generation falling-tile game core: LANES columns, ROWS visible rows of ROW_H pixels, configurable speed ramp.
- Owns row buffer, scroll offset, key judging, speed schedule, score and game state. Answers per-pixel queries for the colour mux with 1-cycle latency.
- Sits between keyboard decode (key_valid/key_lane) and the VGA colour stage. The text overlays stay outside this block.

Parameters:
- LANES, 5, number of columns (2..8)
- ROWS, 4, visible rows (2..8)
- ROW_H, 120, row height in pixels
- LANE_W, 128, lane width in pixels
- SPEED_INIT, 1, pixels per frame at start
- SPEED_STEP, 2, speed increment per level
- SPEED_MAX, 12, speed ceiling
- ROWS_PER_LEVEL, 5, row shifts per speed level
- LFSR_SEED, 8'hA5, nonzero reset seed

Ports:
- pixel_clk, in, 1, sole clock
- Reset_n, in, 1, asynchronous active-low reset
- frame_tick, in, 1, one-cycle pulse per frame, already synchronised to pixel_clk
- key_valid, in, 1, one-cycle key press pulse
- key_lane, in, LW=$clog2(LANES), lane of the press
- restart, in, 1, pulse; honoured only in OVER
- draw_x, in, 10, pixel X
- draw_y, in, 10, pixel Y
- px_tile, out, 1, registered: pixel lies on a tile
- px_hit, out, 1, registered: pixel lies on the already-hit bottom tile
- px_border, out, 1, registered: lane border pixel
- state, out, 2, 0=IDLE, 1=RUN, 2=OVER
- speed, out, 4, current pixels per frame
- score, out, 16, rows hit; saturates at 16'hFFFF
- miss, out, 1, one-cycle pulse on entry to OVER

Behaviour:
Storage
- row_lane[0..ROWS-1] (LW bits each; row 0 is top, row ROWS-1 is bottom), incoming lane, bottom_hit bit.
- offset register, width sized for ROW_H+SPEED_MAX.
- lvl_cnt register.
- 8-bit Galois LFSR with taps 8,6,5,4. Advances every pixel_clk in all states. New lane = lfsr % LANES.

Reset (Reset_n low, asynchronous), and restart while in OVER (synchronous)
- row_lane[k] = (LANES-1-k) % LANES; incoming = 0; bottom_hit = 0; offset = 0; speed = SPEED_INIT; lvl_cnt = 0; score = 0.
- state = IDLE; miss = 0; px_* = 0.
- LFSR = LFSR_SEED on reset only; restart leaves the LFSR running.

States
- IDLE: no scrolling. key_valid is judged as below; if the key is correct, go to RUN.
- RUN: on frame_tick, sum = offset + speed.
  - If sum < ROW_H: offset = sum.
  - Else shift:
    - If bottom_hit == 0: pulse miss, go to OVER, no shift.
    - Otherwise: row_lane[k+1] = row_lane[k]; row_lane[0] = incoming; incoming = new lane; bottom_hit = 0; offset = sum - ROW_H (remainder carried, not discarded); lvl_cnt++.
    - When lvl_cnt reaches ROWS_PER_LEVEL-1 on a shift: lvl_cnt = 0 and speed = min(speed + SPEED_STEP, SPEED_MAX). Exception: the first level-up from speed 1 goes to 2.
- OVER: everything frozen except the LFSR and pixel lookup. Exit only via restart or reset.

Key judging (IDLE or RUN, on key_valid)
- key_lane == row_lane[ROWS-1] and bottom_hit == 0: bottom_hit = 1; score++.
- key_lane == bottom lane and bottom_hit == 1: ignored (repeat tolerance).
- key_lane != bottom lane, or key_lane >= LANES: pulse miss, go to OVER. If this happens in IDLE, state goes IDLE→OVER.
- key_valid and frame_tick in the same cycle: judge the key against the pre-shift bottom row first. A hit in that cycle counts toward the shift decision, so no miss.
- key_valid in OVER: ignored.

Pixel lookup (1-cycle latency)
- lane = draw_x / LANE_W; if lane >= LANES, px_tile = 0.
- y = draw_y - offset, signed. If y < 0, the row is the incoming row.
- Otherwise row = y / ROW_H; if row >= ROWS, px_tile = 0.
- px_tile = (selected row's lane == lane).
- px_hit = px_tile & (row == ROWS-1) & bottom_hit.
- px_border = (draw_x % LANE_W == 0) | (draw_x % LANE_W == LANE_W-1).
- Divides and modulos are by constant parameters only.

Test Plan:
- Reset, defaults → state=0, speed=1, score=0, bottom lane=1. key_lane=1 → state=1, score=1, px_hit=1 at draw_x=200/draw_y=400 one cycle later.
- RUN with bottom hit, 120 frame_ticks at speed 1 → exactly one shift, offset=0, new bottom lane = previous row 2 lane, bottom_hit=0.
- Bottom not hit when sum reaches ROW_H → miss pulse of exactly 1 cycle, state=2, offset frozen across 10 further ticks. restart → state=0, score=0.
- Hit every row for 5 shifts → speed 1→2; after 5 more shifts → 4; continue → saturates at 12 and stays there.
- key_valid with the correct lane coincident with the shifting frame_tick → no miss, shift occurs, score+1. Wrong lane with the same timing → OVER, no shift.
- Speed 12, offset 114 → tick gives sum 126, shift, offset=6. Also: Reset_n asserted mid-RUN asynchronously → all outputs at reset values before the next pixel_clk edge.
